cell_vector_checker: RTL and testbench

//  Synthesizable, self-checking exhaustive driver for one N-input combinational library cell (NOR3_X1 by default).
//  - Applies every input vector 0..2^N_IN-1 in ascending order.
//  - Samples the cell output after a settle window and compares it against a parameterised truth table.
//  - Reports pass/fail, mismatch count and the first failing vector.
//  - Sits beside the DUT cell in cell-characterisation top levels, replacing hand-written per-cell stimulus.

---
 rtl/cell_chk_pkg.sv | 28 ++
 rtl/cell_vector_checker_settle.sv | 41 ++++
 rtl/cell_vector_checker.sv | 174 +++++++++++++++++
 tb/tb_cell_vector_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_chk_pkg
//  Description : Shared definitions for the exhaustive cell vector checker.
//                Holds the checker FSM state encoding and the expected truth
//                tables of common library cells. In each table, bit k is the
//                expected ZN for input vector k.
//  Revision    : 1.0  initial release
// ============================================================================
package cell_chk_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } chk_state_t;

    // Expected truth tables (bit k = ZN for vector k)
    localparam logic [7:0] TT_NOR3  = 8'h01;
    localparam logic [7:0] TT_NAND3 = 8'h7F;
    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_OR3   = 8'hFE;
    localparam logic [1:0] TT_INV   = 2'b01;

endpackage : cell_chk_pkg
`default_nettype wire

// File: rtl/cell_vector_checker_settle.sv
`default_nettype none
// ============================================================================
//  Module      : settle_counter
//  Description : 4-bit settle-window down-counter. It loads SETTLE when the
//                checker enters HOLD and then counts down once per HOLD cycle.
//                'expired' flags a count of zero, which ends HOLD.
//  Revision    : 1.0  initial release
//  Ports       : CK        in   clock, rising edge
//                RN        in   synchronous active-low reset
//                i_load    in   reload with SETTLE (HOLD entry edge)
//                i_dec     in   count down while non-zero
//                o_expired out  counter is at zero
// ============================================================================
module settle_counter #(
    parameter int SETTLE = 2
) (
    input  logic CK,
    input  logic RN,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);

    localparam logic [3:0] c_settle = 4'(SETTLE);

    logic [3:0] r_cnt;

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= c_settle;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expired = (r_cnt == 4'd0);

endmodule : settle_counter
`default_nettype wire

// File: rtl/cell_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : cell_vector_checker
//  Description : Exhaustive stimulus driver and checker for one N-input
//                combinational cell. Vectors 0..2^N_IN-1 are applied in
//                ascending order. Each vector is held for SETTLE+2 cycles, and
//                ZN is compared against EXP_TT at the closing edge of the
//                SAMPLE cycle.
//  Revision    : 1.0  initial release
//  Ports       : CK        in   clock, rising edge
//                RN        in   synchronous active-low reset
//                START     in   begin a run (accepted in IDLE or FIN only)
//                A         out  cell inputs, A[N_IN-1] = A1 (MSB)
//                ZN        in   cell output under test
//                BUSY      out  run in progress
//                DONE      out  results valid, held until next START
//                PASS      out  DONE with zero mismatches
//                ERR_CNT   out  mismatching vector count, saturating
//                FAIL_VLD  out  at least one mismatch this run
//                FAIL_VEC  out  first mismatching vector
// ============================================================================
module cell_vector_checker
    import cell_chk_pkg::*;
#(
    parameter int                      N_IN   = 3,
    parameter int                      SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]    EXP_TT = TT_NOR3
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            START,
    output logic [N_IN-1:0] A,
    input  logic            ZN,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic            FAIL_VLD,
    output logic [N_IN-1:0] FAIL_VEC
);

    localparam logic [N_IN-1:0] c_last_vec = {N_IN{1'b1}};
    localparam logic [N_IN:0]   c_err_max  = {(N_IN+1){1'b1}};

    chk_state_t       r_state;
    chk_state_t       w_state_nxt;
    logic [N_IN-1:0]  r_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [N_IN:0]    r_err_cnt;
    logic             r_fail_vld;
    logic [N_IN-1:0]  r_fail_vec;

    logic             w_start_run;
    logic             w_hold_entry;
    logic             w_last;
    logic             w_mismatch;
    logic [N_IN:0]    w_err_next;
    logic             w_expired;

    // Case inequality so an unknown ZN is scored as a failure in simulation.
    assign w_mismatch = (ZN !== EXP_TT[r_vec]);
    assign w_last     = (r_vec == c_last_vec);
    assign w_err_next = (w_mismatch && (r_err_cnt != c_err_max)) ?
                        (r_err_cnt + 1'b1) : r_err_cnt;

    // ------------------------------------------------------------------
    // Settle window counter
    // ------------------------------------------------------------------
    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .CK        (CK),
        .RN        (RN),
        .i_load    (w_hold_entry),
        .i_dec     (r_state == ST_HOLD),
        .o_expired (w_expired)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (!RN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_start_run  = 1'b0;
        w_hold_entry = 1'b0;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    w_start_run  = 1'b1;
                    w_hold_entry = 1'b1;
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The counter is loaded with SETTLE on entry, so HOLD lasts
                // SETTLE+1 cycles. With SAMPLE, each vector gets SETTLE+2.
                if (w_expired) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_hold_entry = 1'b1;
                    w_state_nxt  = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Vector counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (!RN) begin
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
        end else if (w_start_run) begin
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_err_cnt <= w_err_next;
            if (w_mismatch && !r_fail_vld) begin
                r_fail_vld <= 1'b1;
                r_fail_vec <= r_vec;
            end
            if (w_last) begin
                // A keeps showing the final vector after the run.
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_err_next == '0);
            end else begin
                r_vec <= r_vec + 1'b1;
            end
        end
    end

    assign A        = r_vec;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_pass;
    assign ERR_CNT  = r_err_cnt;
    assign FAIL_VLD = r_fail_vld;
    assign FAIL_VEC = r_fail_vec;

endmodule : cell_vector_checker
`default_nettype wire

// File: tb/tb_cell_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_vector_checker
//  Description : Directed self-checking bench for cell_vector_checker.
//                Instance 1 is the default 3-input/SETTLE=2 configuration
//                driving a selectable cell model. Instance 2 is the
//                2-input/SETTLE=0 configuration driving a NAND2 model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cell_vector_checker;
    import cell_chk_pkg::*;

    logic       ck;
    logic       rn;

    // Instance 1: N_IN=3, SETTLE=2, EXP_TT=NOR3
    logic       start;
    logic [2:0] a;
    logic       zn;
    logic       busy, done, pass, fail_vld;
    logic [3:0] err_cnt;
    logic [2:0] fail_vec;
    int         mode;          // 0 NOR3, 1 OR3, 2 tie 0, 3 tie 1

    // Instance 2: N_IN=2, SETTLE=0, EXP_TT=NAND2
    logic       start2;
    logic [1:0] a2;
    logic       zn2;
    logic       busy2, done2, pass2, fail_vld2;
    logic [2:0] err_cnt2;
    logic [1:0] fail_vec2;
    logic       x_mode;
    logic       xv;

    int errs     = 0;
    int n_checks = 0;

    cell_vector_checker #(
        .N_IN   (3),
        .SETTLE (2),
        .EXP_TT (TT_NOR3)
    ) u_dut (
        .CK       (ck),
        .RN       (rn),
        .START    (start),
        .A        (a),
        .ZN       (zn),
        .BUSY     (busy),
        .DONE     (done),
        .PASS     (pass),
        .ERR_CNT  (err_cnt),
        .FAIL_VLD (fail_vld),
        .FAIL_VEC (fail_vec)
    );

    cell_vector_checker #(
        .N_IN   (2),
        .SETTLE (0),
        .EXP_TT (4'h7)
    ) u_dut2 (
        .CK       (ck),
        .RN       (rn),
        .START    (start2),
        .A        (a2),
        .ZN       (zn2),
        .BUSY     (busy2),
        .DONE     (done2),
        .PASS     (pass2),
        .ERR_CNT  (err_cnt2),
        .FAIL_VLD (fail_vld2),
        .FAIL_VEC (fail_vec2)
    );

    // Cell models
    always_comb begin
        case (mode)
            0:       zn = ~|a;
            1:       zn = |a;
            2:       zn = 1'b0;
            default: zn = 1'b1;
        endcase
    end

    // On a 2-state simulator the X cannot be represented. Drive the wrong
    // value instead so that a mismatch is still seen.
    always_comb begin
        if (x_mode && (a2 == 2'b10))
            zn2 = $isunknown(xv) ? xv : 1'b0;
        else
            zn2 = ~(a2[1] & a2[0]);
    end

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Pulse START on instance 1. On return, time is just after the START edge.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges after the START edge until DONE. Optionally poke START at a
    // given cycle and optionally check the A sequence.
    task automatic wait_done1(input int poke_at, input bit chk_seq, output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            if (cycles == poke_at) start = 1'b1;
            tick();
            start = 1'b0;
            cycles++;
            if (chk_seq && (cycles % 4 == 1) && cycles < 32)
                check("t1_a_seq", 32'(a), 32'(cycles / 4));
        end
    endtask

    initial begin
        int cyc;
        xv     = 1'bx;
        rn     = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        x_mode = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_a",        32'(a),        32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_pass",     32'(pass),     32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        check("rst_fail_vld", 32'(fail_vld), 32'd0);
        check("rst_fail_vec", 32'(fail_vec), 32'd0);
        check("rst_busy2",    32'(busy2),    32'd0);
        rn = 1'b1;
        tick();

        // 1. NOR3 cell passes in 32 cycles
        pulse_start();
        check("t1_busy_start", 32'(busy), 32'd1);
        check("t1_a_start",    32'(a),    32'd0);
        wait_done1(-1, 1'b1, cyc);
        check("t1_cycles",   32'(cyc),      32'd32);
        check("t1_pass",     32'(pass),     32'd1);
        check("t1_err_cnt",  32'(err_cnt),  32'd0);
        check("t1_fail_vld", 32'(fail_vld), 32'd0);
        check("t1_busy",     32'(busy),     32'd0);
        check("t1_a_last",   32'(a),        32'd7);

        // 2. OR3 cell against the NOR3 table: every vector fails
        mode = 1;
        pulse_start();
        wait_done1(-1, 1'b0, cyc);
        check("t2_err_cnt",  32'(err_cnt),  32'd8);
        check("t2_fail_vld", 32'(fail_vld), 32'd1);
        check("t2_fail_vec", 32'(fail_vec), 32'd0);
        check("t2_pass",     32'(pass),     32'd0);

        // 3. Tied outputs
        mode = 2;
        pulse_start();
        wait_done1(-1, 1'b0, cyc);
        check("t3_tie0_err_cnt",  32'(err_cnt),  32'd1);
        check("t3_tie0_fail_vec", 32'(fail_vec), 32'd0);
        mode = 3;
        pulse_start();
        wait_done1(-1, 1'b0, cyc);
        check("t3_tie1_err_cnt",  32'(err_cnt),  32'd7);
        check("t3_tie1_fail_vec", 32'(fail_vec), 32'd1);
        check("t3_tie1_pass",     32'(pass),     32'd0);

        // 4. Reset mid-run at A=101 discards partial results
        pulse_start();
        cyc = 0;
        while (a != 3'd5 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t4_reach_a5", 32'(a), 32'd5);
        rn = 1'b0;
        tick();
        check("t4_a",        32'(a),        32'd0);
        check("t4_busy",     32'(busy),     32'd0);
        check("t4_done",     32'(done),     32'd0);
        check("t4_err_cnt",  32'(err_cnt),  32'd0);
        check("t4_fail_vld", 32'(fail_vld), 32'd0);
        check("t4_fail_vec", 32'(fail_vec), 32'd0);
        rn   = 1'b1;
        mode = 0;
        tick();
        pulse_start();
        check("t4_restart_a", 32'(a), 32'd0);
        wait_done1(-1, 1'b0, cyc);
        check("t4_restart_cycles", 32'(cyc),  32'd32);
        check("t4_restart_pass",   32'(pass), 32'd1);

        // 5. START while busy is ignored; START in FIN clears results
        mode = 3;
        pulse_start();
        wait_done1(10, 1'b0, cyc);
        check("t5_cycles",  32'(cyc),     32'd32);
        check("t5_err_cnt", 32'(err_cnt), 32'd7);
        pulse_start();
        check("t5_fin_done",     32'(done),     32'd0);
        check("t5_fin_err_cnt",  32'(err_cnt),  32'd0);
        check("t5_fin_fail_vld", 32'(fail_vld), 32'd0);
        check("t5_fin_busy",     32'(busy),     32'd1);
        check("t5_fin_a",        32'(a),        32'd0);
        mode = 0;
        wait_done1(-1, 1'b0, cyc);
        check("t5_rerun_pass", 32'(pass), 32'd1);

        // 6. N_IN=2, SETTLE=0, NAND2
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t6_cycles",  32'(cyc),      32'd8);
        check("t6_pass",    32'(pass2),    32'd1);
        check("t6_err_cnt", 32'(err_cnt2), 32'd0);
        x_mode = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t6x_cycles",   32'(cyc),       32'd8);
        check("t6x_err_cnt",  32'(err_cnt2),  32'd1);
        check("t6x_fail_vld", 32'(fail_vld2), 32'd1);
        check("t6x_fail_vec", 32'(fail_vec2), 32'd2);
        check("t6x_pass",     32'(pass2),     32'd0);

        $display("Result: errors=%0d of %0d checks", errs, n_checks);
        $finish;
    end

endmodule : tb_cell_vector_checker
`default_nettype wire
